// File: rtl/parity_pkg.sv
// Shared definitions for the streaming parity/LRC frame checker and its word checker.
package parity_pkg;

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_word_chk.sv
// Combinational single-word parity checker; err is high when data plus its parity bit
// does not have the number of ones that the selected mode asks for.
module parity_word_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              odd_mode,
  output logic              err
);

  logic ones_odd;

  assign ones_odd = ^{data, par};
  assign err      = (ones_odd != (odd_mode == PAR_ODD));

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming word-parity and frame LRC checker with registered error pulses,
// a saturating error counter and a sticky error flag.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              odd_mode,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  output logic              word_err,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] lrc_acc;
  logic              frame_acc;

  logic              par_err;
  logic              first_word;
  logic              restart;
  logic              is_check;
  logic              lrc_bad;
  logic              bad_word;
  logic [IDX_W-1:0]  word_pos;

  parity_word_chk #(
    .DATA_W(DATA_W)
  ) u_word_chk (
    .data    (in_data),
    .par     (in_par),
    .odd_mode(odd_mode),
    .err     (par_err)
  );

  // A sof anywhere but the first data slot restarts the frame with this word as word 0,
  // so a sof landing on the check slot is treated as data, never as the LRC.
  assign first_word = (state == ST_DATA) && (idx == '0);
  assign restart    = in_sof && !first_word;
  assign is_check   = (state == ST_CHECK) && !restart;
  assign lrc_bad    = is_check && (in_data != lrc_acc);
  assign bad_word   = par_err || lrc_bad;
  assign word_pos   = restart ? '0 : idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_DATA;
      idx         <= '0;
      lrc_acc     <= '0;
      frame_acc   <= 1'b0;
      out_valid   <= 1'b0;
      word_err    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_abort <= 1'b0;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      word_err    <= in_valid && par_err;
      frame_done  <= in_valid && is_check;
      frame_err   <= in_valid && is_check && (frame_acc || par_err || lrc_bad);
      frame_abort <= in_valid && restart;

      if (in_valid) begin
        if (is_check) begin
          state     <= ST_DATA;
          idx       <= '0;
          lrc_acc   <= '0;
          frame_acc <= 1'b0;
        end else begin
          if (restart) begin
            lrc_acc   <= in_data;
            frame_acc <= par_err;
          end else begin
            lrc_acc   <= lrc_acc ^ in_data;
            frame_acc <= frame_acc || par_err;
          end
          if (word_pos == LAST_IDX) begin
            state <= ST_CHECK;
            idx   <= '0;
          end else begin
            state <= ST_DATA;
            idx   <= word_pos + IDX_W'(1);
          end
        end
      end

      // clr wins over a same-cycle error; the word still shows up on word_err/frame_err
      if (clr) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else if (in_valid && bad_word) begin
        err_sticky <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker: default-width instance plus
// a 2-bit counter instance sharing the same stimulus for the saturation case.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       odd_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_par = 1'b0;

  logic       out_valid, word_err, frame_done, frame_err, frame_abort, err_sticky;
  logic [7:0] err_cnt;
  logic       s_out_valid, s_word_err, s_frame_done, s_frame_err, s_frame_abort, s_err_sticky;
  logic [1:0] s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(4), .FRAME_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid), .word_err(word_err), .frame_done(frame_done),
    .frame_err(frame_err), .frame_abort(frame_abort),
    .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  parity_frame_checker #(.DATA_W(4), .FRAME_LEN(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_par(in_par),
    .out_valid(s_out_valid), .word_err(s_word_err), .frame_done(s_frame_done),
    .frame_err(s_frame_err), .frame_abort(s_frame_abort),
    .err_cnt(s_err_cnt), .err_sticky(s_err_sticky)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic v, input logic sof, input logic odd,
                               input logic [3:0] d, input logic p, input logic c);
    in_valid = v;
    in_sof   = sof;
    odd_mode = odd;
    in_data  = d;
    in_par   = p;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst word_err", word_err, 0);
    checkOutput("rst frame_done", frame_done, 0);
    checkOutput("rst err_cnt", err_cnt, 0);
    checkOutput("rst err_sticky", err_sticky, 0);
    rst_n = 1'b1;

    // Even-mode good frame, LRC 0xA
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0);
    checkOutput("t1 out_valid", out_valid, 1);
    checkOutput("t1 w0 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    checkOutput("t1 w1 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0);
    checkOutput("t1 w2 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("t1 w3 frame_done", frame_done, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("t1 frame_done", frame_done, 1);
    checkOutput("t1 frame_err", frame_err, 0);
    checkOutput("t1 err_cnt", err_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("idle out_valid", out_valid, 0);
    checkOutput("idle frame_done", frame_done, 0);

    // Per-word mode switching, all parities correct
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
    checkOutput("mix w1 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("mix w3 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0);
    checkOutput("mix frame_done", frame_done, 1);
    checkOutput("mix frame_err", frame_err, 0);
    checkOutput("mix err_cnt", err_cnt, 0);

    // Word 2 has a parity error
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0);
    checkOutput("t2 word_err", word_err, 1);
    checkOutput("t2 err_cnt early", err_cnt, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("t2 w3 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("t2 frame_done", frame_done, 1);
    checkOutput("t2 frame_err", frame_err, 1);
    checkOutput("t2 err_cnt", err_cnt, 1);
    checkOutput("t2 err_sticky", err_sticky, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("clr err_cnt", err_cnt, 0);
    checkOutput("clr err_sticky", err_sticky, 0);

    // Odd mode, correct parities, bad LRC 0xB
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    checkOutput("t3 w3 word_err", word_err, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
    checkOutput("t3 word_err", word_err, 0);
    checkOutput("t3 frame_done", frame_done, 1);
    checkOutput("t3 frame_err", frame_err, 1);
    checkOutput("t3 err_cnt", err_cnt, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

    // sof on word 2 restarts the frame; new frame 7,F,1,3 -> LRC 0xA
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
    checkOutput("t4 sof0 frame_abort", frame_abort, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
    checkOutput("t4 frame_abort", frame_abort, 1);
    checkOutput("t4 abort frame_done", frame_done, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("t4 abort pulse", frame_abort, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    checkOutput("t4 early done", frame_done, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("t4 frame_done", frame_done, 1);
    checkOutput("t4 frame_err", frame_err, 0);
    checkOutput("t4 err_cnt", err_cnt, 0);

    // Five bad words (fifth is the check slot); 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
      checkOutput($sformatf("t5 word_err %0d", i), word_err, 1);
      checkOutput($sformatf("t5 err_cnt %0d", i), err_cnt, i + 1);
      checkOutput($sformatf("t5 sat err_cnt %0d", i), s_err_cnt, (i < 3) ? i + 1 : 3);
    end
    checkOutput("t5 frame_done", frame_done, 1);
    checkOutput("t5 frame_err", frame_err, 1);
    checkOutput("t5 sat sticky", s_err_sticky, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1);
    checkOutput("t5 clr err_cnt", s_err_cnt, 0);
    checkOutput("t5 clr sticky", s_err_sticky, 0);
    checkOutput("t5 clr word_err", s_word_err, 1);
    checkOutput("t5 clr main cnt", err_cnt, 0);

    // Mid-frame reset after 2 words, with a sof that would otherwise abort
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    checkOutput("t6 out_valid", out_valid, 0);
    checkOutput("t6 word_err", word_err, 0);
    checkOutput("t6 frame_abort", frame_abort, 0);
    checkOutput("t6 frame_err", frame_err, 0);
    checkOutput("t6 err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0);
    checkOutput("t6 w0 abort", frame_abort, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    checkOutput("t6 frame_done", frame_done, 1);
    checkOutput("t6 frame_err", frame_err, 0);
    checkOutput("t6 err_sticky", err_sticky, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Streaming, parametrised successor to the 4-bit combinational even-parity checker.
- Accepts one DATA_W-bit word plus its parity bit per valid cycle and checks each word in even or odd mode, selectable per word.
- Groups words into frames of FRAME_LEN data words followed by one longitudinal check word (LRC = XOR of the frame's data words), and checks that as well.
- Registered error pulses, a saturating error counter and a sticky flag; sits at the receive side of serial/parallel links ahead of the error-handling logic.

Parameters:
- DATA_W, 4: data word width in bits (>=1).
- FRAME_LEN, 4: data words per frame, excluding the check word (>=1).
- CNT_W, 8: width of the error counter (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear of err_cnt and err_sticky.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled with each accepted word.
- in_valid  in  1  word present this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_data  in  DATA_W  data word, or LRC on the check word.
- in_par  in  1  parity bit of in_data.
- out_valid  out  1  registered copy of in_valid.
- word_err  out  1  parity error on the word accepted last cycle.
- frame_done  out  1  pulse: check word accepted last cycle.
- frame_err  out  1  valid with frame_done: any word parity error in the frame, or LRC mismatch.
- frame_abort  out  1  pulse: partial frame discarded by in_sof.
- err_cnt  out  CNT_W  saturating count of erroneous words.
- err_sticky  out  1  set on any erroneous word; cleared only by clr or reset.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs to 0, state to DATA, word index to 0, LRC accumulator to 0 and the frame-error accumulator to 0. Reset mid-frame discards the frame without a frame_abort.
- Word parity: p = XOR of in_data and in_par. Error if p != odd_mode: even mode expects an even number of ones, odd mode an odd number.
- The check word's parity bit is checked the same way.
- All outputs are registered with 1-cycle latency from the accepting edge. When in_valid=0, word_err, frame_done and frame_abort are 0 and state is held.
- FSM has two states:
  - DATA: each valid word XORs into the LRC accumulator, ORs its parity error into the frame accumulator and increments the index. On the FRAME_LEN-th word, go to CHECK.
  - CHECK: the valid word is the LRC. lrc_bad = (in_data != accumulator). frame_done=1 and frame_err = (frame accumulator | word parity error | lrc_bad). Then reset the index, accumulators and state to DATA.
- in_sof with in_valid:
  - Index 0 in DATA: normal first word, no abort.
  - Any other position, including CHECK: frame_abort=1 next cycle and the partial frame is discarded. The sof word becomes word 0 of a new frame (LRC accumulator = in_data, index = 1, or go straight to CHECK if FRAME_LEN=1).
  - in_sof is not required; frames free-run back to back.
- Erroneous word: parity error, or lrc_bad on the check word. Each erroneous word increments err_cnt by exactly 1, saturating at 2^CNT_W-1 (no wrap), and sets err_sticky.
- clr has priority: err_cnt=0 and err_sticky=0 even if an erroneous word is accepted the same cycle. That event is dropped from err_cnt/err_sticky, but word_err and frame_err still report it.
- word_err reports the parity error only, never lrc_bad.
- odd_mode may change on any word; each word is checked with its own sampled mode.

Decomposition:
- Shared package parity_pkg: state enum (ST_DATA, ST_CHECK), mode constants (PAR_EVEN=0, PAR_ODD=1).
- Sub-module parity_word_chk (combinational, parameter DATA_W): inputs data, par, odd_mode; output err. Instantiated once and reusable elsewhere.
- Top level holds the FSM, index counter, accumulators, counter and sticky flag.

Test Plan:
- Reset then even mode, frame 0x1/p1, 0x3/p0, 0x7/p1, 0xF/p0, check 0xA/p0 -> word_err=0 throughout, frame_done=1 with frame_err=0, err_cnt=0.
- Same frame but word 2 sent as 0x7/p0 -> word_err=1 one cycle later; frame_done with frame_err=1; err_cnt=1; err_sticky=1.
- Odd mode, correct parities, check word 0xB instead of 0xA -> word_err=0 on all words; frame_err=1; err_cnt=1.
- in_sof on the 3rd word of a frame -> frame_abort=1 next cycle; the frame then completes 3 words later with correct LRC -> frame_err=0.
- CNT_W=2, 5 consecutive bad words -> err_cnt=1, 2, 3, 3, 3. Then clr together with a bad word -> err_cnt=0, err_sticky=0, word_err=1.
- Assert rst_n=0 mid-frame after 2 words -> all outputs 0, no frame_abort. A following full correct frame -> frame_done=1, frame_err=0.
